regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Writeback arbiter and busy scoreboard for the 32x32 register file. It shares the register file's single write port between two writeback requesters: req0 is the ALU and req1 is the load unit. It also tracks which architectural registers have a write outstanding, so the issue stage can stall on RAW hazards. It sits between the execute/load stages and the register file write port (we/waddr/wdat).

## Interface
Parameters:
- DW, 32, data width of the register file
- AW, 5, register address width; the register count is 2**AW

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- r0_valid  in  1  ALU writeback request
- r0_ready  out  1  ALU request granted this cycle
- r0_addr  in  AW  ALU destination register
- r0_data  in  DW  ALU result
- r1_valid / r1_ready / r1_addr / r1_data  same as r0_*, for the load unit
- iss_valid  in  1  an instruction with destination iss_rd is issued this cycle
- iss_rd  in  AW  destination register of the issued instruction
- rs1, rs2  in  AW  source registers queried by the issue stage
- rs1_busy, rs2_busy  out  1  queried register has an outstanding write
- busy_vec  out  2**AW  full scoreboard; bit 0 is always 0
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  AW  register file write address (registered)
- rf_wdat  out  DW  register file write data (registered)

## Operation
- **Grant logic:**
  - r0_ready and r1_ready are combinational from the valids and the priority pointer `prio`.
  - Exactly one ready is asserted if any valid is high; none if both are low.
  - If only one request is valid, that request is granted.
  - If both are valid, the request `prio` points to is granted.
  - After any two-way contention, `prio` flips to the loser. A grant without contention leaves `prio` unchanged.
- **Transfer:** a transfer occurs when valid && ready. The requester must hold addr/data stable while valid && !ready.
- **Write launch:** on a transfer, at the next edge:
  - rf_waddr <= addr and rf_wdat <= data.
  - rf_we <= (addr != 0); a write to x0 is accepted and then dropped.
  - With no transfer, rf_we <= 0, and rf_waddr/rf_wdat hold their values.
- **Scoreboard set:** on iss_valid && iss_rd != 0, busy[iss_rd] is set at the next edge.
- **Scoreboard clear:** when rf_we is high, busy[rf_waddr] is cleared at the end of that cycle. This is the same edge at which the register file commits the write, so a stalled reader sees busy=0 only once the register file already holds the new value.
- **Simultaneous set and clear on the same register:** set wins, because a new writer is pending.
- **Issue to a register that is already busy (WAW):** the bit stays set and is cleared by the first writeback to that register. Issue ordering is the issue stage's responsibility.
- **Writeback to a register that is not busy:** the write is performed; busy is unchanged.
- **Busy queries:** rs1_busy = busy[rs1] and rs2_busy = busy[rs2], combinational. busy[0] is hard-wired to 0.

## Timing
- **Reset values:** rf_we=0, rf_waddr=0, rf_wdat=0, busy_vec=0, prio=req0. r0_ready and r1_ready are forced to 0 while rst is high.
- **Latency:**
  - Accepted transfer at edge N, so rf_we is high in cycle N+1.
  - The register file commits at edge N+1, and busy clears at edge N+1.
- **Throughput:** one writeback per cycle, sustained. Under continuous contention, grants alternate r0, r1, r0, ... starting with r0 after reset.
- **Reset during operation:** any transfer at the reset edge is discarded; no rf_we in the following cycle. All busy bits clear.
- There is no combinational path from rf_* or busy to ready.

## Test plan
- **Reset:** assert rst for 2 cycles with both valids high. Require r*_ready=0, then rf_we=0 and busy_vec=0 in the cycle after release.
- **Single write:** r0 writes addr=5, data=0xDEADBEEF. Require r0_ready=1 in the same cycle. Next cycle require rf_we=1, rf_waddr=5, rf_wdat=0xDEADBEEF. The following cycle require rf_we=0.
- **Contention:** hold r0 (addr 3, 0x11) and r1 (addr 4, 0x22) valid continuously. Require rf_waddr sequence 3, 4, 3, 4 (r1 re-presents new data after each grant), with no idle cycles.
- **Scoreboard:**
  - Issue rd=7, then query rs1=7: require rs1_busy=1.
  - r1 writes reg 7: require rs1_busy=1 in the cycle rf_we=1, and 0 in the cycle after.
  - Issuing rd=0 leaves busy_vec=0.
- **Set/clear collision:** in the cycle rf_we=1 with rf_waddr=9, also issue iss_rd=9. Require busy[9]=1 afterwards.
- **x0 drop and mid-op reset:**
  - r0 writes addr 0: require r0_ready=1, then rf_we=0.
  - Start a transfer to reg 12 and assert rst on the same edge: require rf_we=0 next cycle and busy_vec=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port, plus a busy scoreboard
// that marks registers with an outstanding write for RAW stall detection.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [AW-1:0]     r0_addr,
  input  logic [DW-1:0]     r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [AW-1:0]     r1_addr,
  input  logic [DW-1:0]     r1_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [(1<<AW)-1:0] busy_vec,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdat
);
  localparam int NREG = 1 << AW;

  // Handshake: a transfer happens on a cycle where valid && ready; a requester
  // holds addr/data stable while valid && !ready. ready never depends on rf_*
  // or busy, only on the valids, prio and rst.

  logic            prio;     // 0 = req0 wins contention, 1 = req1 wins
  logic            contend;
  logic            xfer0;
  logic            xfer1;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  always_comb begin
    contend  = r0_valid && r1_valid;
    r0_ready = !rst && r0_valid && (!r1_valid || !prio);
    r1_ready = !rst && r1_valid && (!r0_valid || prio);
    xfer0    = r0_valid && r0_ready;
    xfer1    = r1_valid && r1_ready;
  end

  // Clear happens on the same edge as the register file commit; a set on the
  // same register in that cycle wins because a newer writer is pending.
  always_comb begin
    busy_next = busy;
    if (rf_we) busy_next[rf_waddr] = 1'b0;
    if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    busy_vec = busy;
    rs1_busy = busy[rs1];
    rs2_busy = busy[rs2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdat  <= '0;
      busy     <= '0;
    end else begin
      // After contention the loser gets priority next time.
      if (contend) prio <= ~prio;
      if (xfer0) begin
        rf_we    <= (r0_addr != '0);
        rf_waddr <= r0_addr;
        rf_wdat  <= r0_data;
      end else if (xfer1) begin
        rf_we    <= (r1_addr != '0);
        rf_waddr <= r1_addr;
        rf_wdat  <= r1_data;
      end else begin
        rf_we <= 1'b0;
      end
      busy <= busy_next;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention,
// scoreboard set/clear, set/clear collision, x0 drop and mid-operation reset.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_ready;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_data;
  logic          r1_valid, r1_ready;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd, rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic [31:0]   busy_vec;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdat;

  int vectors = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_vec(busy_vec),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdat(rf_wdat)
  );

  // Clock: posedge at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'h1;
    r1_valid = 1'b1; r1_addr = 5'd2; r1_data = 32'h2;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;

    // Reset held for two edges with both valids high
    #1;
    chk("rst_r0_ready", 64'(r0_ready), 64'd0);
    chk("rst_r1_ready", 64'(r1_ready), 64'd0);
    tick();
    tick();
    chk("rst_r0_ready_2", 64'(r0_ready), 64'd0);
    chk("rst_r1_ready_2", 64'(r1_ready), 64'd0);
    rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdat", 64'(rf_wdat), 64'd0);
    tick();
    chk("post_rst_rf_we", 64'(rf_we), 64'd0);
    chk("post_rst_busy", 64'(busy_vec), 64'd0);

    // Single write from r0
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'hDEADBEEF;
    #1;
    chk("single_r0_ready", 64'(r0_ready), 64'd1);
    chk("single_r1_ready", 64'(r1_ready), 64'd0);
    tick();
    r0_valid = 1'b0;
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_wdat", 64'(rf_wdat), 64'hDEADBEEF);
    tick();
    chk("single_we_off", 64'(rf_we), 64'd0);
    chk("single_waddr_hold", 64'(rf_waddr), 64'd5);
    chk("single_wdat_hold", 64'(rf_wdat), 64'hDEADBEEF);

    // Continuous contention: grants alternate r0, r1, r0, r1
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'h11;
    r1_valid = 1'b1; r1_addr = 5'd4; r1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_r0_ready", 64'(r0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("cont_r1_ready", 64'(r1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
      chk("cont_we", 64'(rf_we), 64'd1);
      chk("cont_waddr", 64'(rf_waddr), (i % 2 == 0) ? 64'd3 : 64'd4);
      chk("cont_wdat", 64'(rf_wdat), (i == 0 || i == 2) ? 64'h11 : (i == 1) ? 64'h22 : 64'h23);
      if (i == 1) r1_data = 32'h23;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Scoreboard: issue rd=7 and query it on both ports
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    chk("sb_pre_busy", 64'(rs1_busy), 64'd0);
    tick();
    iss_valid = 1'b0;
    chk("sb_rs1_busy", 64'(rs1_busy), 64'd1);
    chk("sb_rs2_busy", 64'(rs2_busy), 64'd1);
    chk("sb_vec", 64'(busy_vec), 64'h80);
    rs2 = 5'd6;
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h77;
    #1;
    chk("sb_rs2_idle", 64'(rs2_busy), 64'd0);
    chk("sb_r1_ready", 64'(r1_ready), 64'd1);
    tick();
    r1_valid = 1'b0;
    chk("sb_wb_we", 64'(rf_we), 64'd1);
    chk("sb_wb_waddr", 64'(rf_waddr), 64'd7);
    chk("sb_wb_still_busy", 64'(rs1_busy), 64'd1);
    tick();
    chk("sb_cleared", 64'(rs1_busy), 64'd0);
    chk("sb_cleared_vec", 64'(busy_vec), 64'd0);

    // Issue to x0 never marks busy
    iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
    tick();
    iss_valid = 1'b0;
    chk("x0_issue_vec", 64'(busy_vec), 64'd0);
    chk("x0_issue_rs1", 64'(rs1_busy), 64'd0);

    // Set/clear collision on reg 9: the set wins
    iss_valid = 1'b1; iss_rd = 5'd9;
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 32'h99;
    tick();
    iss_valid = 1'b0; r0_valid = 1'b0;
    chk("coll_busy_set", 64'(busy_vec), 64'h200);
    chk("coll_we", 64'(rf_we), 64'd1);
    chk("coll_waddr", 64'(rf_waddr), 64'd9);
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    chk("coll_set_wins", 64'(busy_vec), 64'h200);
    chk("coll_we_off", 64'(rf_we), 64'd0);

    // Write to x0 is accepted and dropped
    r0_valid = 1'b1; r0_addr = 5'd0; r0_data = 32'h55;
    #1;
    chk("x0_r0_ready", 64'(r0_ready), 64'd1);
    tick();
    r0_valid = 1'b0;
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_busy_kept", 64'(busy_vec), 64'h200);

    // Transfer to reg 12 coincident with reset is discarded
    r0_valid = 1'b1; r0_addr = 5'd12; r0_data = 32'hC;
    iss_valid = 1'b1; iss_rd = 5'd12;
    rst = 1'b1;
    #1;
    chk("midrst_r0_ready", 64'(r0_ready), 64'd0);
    tick();
    rst = 1'b0; iss_valid = 1'b0;
    chk("midrst_we", 64'(rf_we), 64'd0);
    chk("midrst_busy", 64'(busy_vec), 64'd0);
    chk("midrst_waddr", 64'(rf_waddr), 64'd0);

    // Priority restarts at r0 after reset
    r1_valid = 1'b1; r1_addr = 5'd13; r1_data = 32'hD;
    #1;
    chk("midrst_prio_r0", 64'(r0_ready), 64'd1);
    chk("midrst_prio_r1", 64'(r1_ready), 64'd0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("midrst_after_we", 64'(rf_we), 64'd1);
    chk("midrst_after_waddr", 64'(rf_waddr), 64'd12);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
